// File: rtl/axi_mm_chk_sequencer.sv
// axi_mm_chk_sequencer
// ---------------------------------------------------------------------------
// Iteration sequencer for the AXI-MM pattern checker, rdclk domain.
// Each iteration does four things in order:
//   1. arms the checker;
//   2. waits out the checker's blanking window;
//   3. launches one pattern-generator burst;
//   4. waits for a verdict or a timeout, then idles for cfg_gap cycles.
// Iterations repeat cfg_num_iter times (0 = until stop). Pass, fail and
// timeout results are accumulated for software.
//
// Ports
//   rdclk, rst_n    clock; synchronous active-low reset
//   start, stop     single-cycle control pulses
//   cfg_num_iter    iterations per run (0 = continuous)
//   cfg_burst_len   beats per burst, presented on patgen_cnt
//   cfg_gap         idle cycles between iterations
//   cfg_timeout     max WAIT cycles per iteration (nonzero)
//   chkr_fifo_full  checker expected-data FIFO full; holds off a launch
//   patchkr_out     checker verdict: 11 pass, 10 fail, 00 pending
//   patchkr_en      one-cycle checker arm pulse
//   patgen_start    one-cycle burst launch pulse
//   patgen_cnt      latched burst length
//   busy            high outside IDLE
//   done            one-cycle end-of-run pulse
//   pass            run result, valid from done until the next start
//   timeout_err     sticky timeout flag
//   iter_cnt        completed iterations (wraps)
//   pass_cnt        pass verdict count (saturates at 255)
//   fail_cnt        fail/timeout count (saturates at 255)
//   state_dbg       current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module axi_mm_chk_sequencer #(
  parameter int BLANK_CYC = 6,
  parameter int TMO_W     = 16
) (
  input  logic             rdclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       cfg_num_iter,
  input  logic [7:0]       cfg_burst_len,
  input  logic [7:0]       cfg_gap,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             chkr_fifo_full,
  input  logic [1:0]       patchkr_out,
  output logic             patchkr_en,
  output logic             patgen_start,
  output logic [7:0]       patgen_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout_err,
  output logic [7:0]       iter_cnt,
  output logic [7:0]       pass_cnt,
  output logic [7:0]       fail_cnt,
  output logic [2:0]       state_dbg
);

  localparam int            BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_BLANK  = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_GAP    = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t state, next_state;

  // Configuration captured at start so it cannot change under a running test.
  logic [7:0]       num_iter_q;
  logic [7:0]       gap_q;
  logic [TMO_W-1:0] timeout_q;
  logic             stop_pend;

  logic [BW-1:0]    blank_cnt;
  logic [7:0]       gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  // Next-cycle values of the registered control outputs.
  logic patchkr_en_d, patgen_start_d, busy_d, done_d;

  // Status decodes
  logic       verdict_pass, verdict_fail, tmo_hit;
  logic       gap_exit, last_iter;
  logic [7:0] iter_next;

  assign verdict_pass = (state == S_WAIT) && (patchkr_out == 2'b11);
  assign verdict_fail = (state == S_WAIT) && (patchkr_out == 2'b10);
  // tmo_cnt is 0 in the WAIT entry cycle, so the hit lands T+1 cycles in.
  assign tmo_hit      = (state == S_WAIT) && !verdict_pass && !verdict_fail &&
                        (tmo_cnt == timeout_q);
  // gap_cnt is 0 in the GAP entry cycle; cfg_gap=0 exits immediately.
  assign gap_exit     = (state == S_GAP) && (gap_cnt == gap_q);
  assign iter_next    = iter_cnt + 8'd1;
  assign last_iter    = stop_pend || ((num_iter_q != 8'd0) && (iter_next == num_iter_q));

  assign state_dbg    = state;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge rdclk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // Launch handshake: chkr_fifo_full acts as an inverted ready. A burst is
  // launched only when full is low; patgen_start is a flop, so full is
  // sampled in the cycle before the pulse (the last BLANK cycle or a
  // stalled LAUNCH cycle). The FSM leaves LAUNCH in the cycle the pulse
  // is visible.
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start)                    next_state = S_ARM;
      S_ARM:                                  next_state = S_BLANK;
      S_BLANK:  if (blank_cnt == BLANK_LAST)  next_state = S_LAUNCH;
      S_LAUNCH: if (patgen_start)             next_state = S_WAIT;
      S_WAIT:   if (verdict_pass || verdict_fail || tmo_hit)
                                              next_state = S_GAP;
      S_GAP:    if (gap_exit)                 next_state = last_iter ? S_FIN : S_ARM;
      S_FIN:                                  next_state = S_IDLE;
      default:                                next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (decoded from next_state, then registered so each pulse
  // lines up with the state it belongs to)
  // ---------------------------------------------------------------------
  always_comb begin
    busy_d         = (next_state != S_IDLE);
    patchkr_en_d   = (next_state == S_ARM);
    patgen_start_d = (next_state == S_LAUNCH) && !chkr_fifo_full;
    done_d         = (next_state == S_FIN);
  end

  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      patchkr_en   <= 1'b0;
      patgen_start <= 1'b0;
      done         <= 1'b0;
    end else begin
      busy         <= busy_d;
      patchkr_en   <= patchkr_en_d;
      patgen_start <= patgen_start_d;
      done         <= done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: config latch, phase timers, result accounting
  // ---------------------------------------------------------------------
  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      num_iter_q  <= 8'd0;
      gap_q       <= 8'd0;
      timeout_q   <= '0;
      patgen_cnt  <= 8'd0;
      stop_pend   <= 1'b0;
      blank_cnt   <= '0;
      gap_cnt     <= 8'd0;
      tmo_cnt     <= '0;
      iter_cnt    <= 8'd0;
      pass_cnt    <= 8'd0;
      fail_cnt    <= 8'd0;
      timeout_err <= 1'b0;
      pass        <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        num_iter_q  <= cfg_num_iter;
        gap_q       <= cfg_gap;
        timeout_q   <= cfg_timeout;
        patgen_cnt  <= cfg_burst_len;
        iter_cnt    <= 8'd0;
        pass_cnt    <= 8'd0;
        fail_cnt    <= 8'd0;
        timeout_err <= 1'b0;
        pass        <= 1'b0;
        // A stop arriving with start limits the run to one iteration.
        stop_pend   <= stop;
      end else if (state != S_IDLE && stop) begin
        stop_pend   <= 1'b1;
      end

      // Each timer is held at zero outside its own state, so it always
      // starts from zero on entry.
      blank_cnt <= (state == S_BLANK) ? blank_cnt + BW'(1) : '0;
      gap_cnt   <= (state == S_GAP)   ? gap_cnt + 8'd1     : 8'd0;
      tmo_cnt   <= (state == S_WAIT)  ? tmo_cnt + TMO_W'(1) : '0;

      if (verdict_pass && pass_cnt != 8'hFF)
        pass_cnt <= pass_cnt + 8'd1;
      if ((verdict_fail || tmo_hit) && fail_cnt != 8'hFF)
        fail_cnt <= fail_cnt + 8'd1;
      if (tmo_hit)
        timeout_err <= 1'b1;

      if (gap_exit)
        iter_cnt <= iter_next;
      // The counters were last updated on GAP entry, so they are final here.
      if (gap_exit && last_iter)
        pass <= (fail_cnt == 8'd0) && !timeout_err;
    end
  end

endmodule

// File: tb/tb_axi_mm_chk_sequencer.sv
// Directed testbench for axi_mm_chk_sequencer. Cycle 0 is the cycle in which
// start is driven; inputs are driven and outputs sampled 1 ns after each
// rising edge.
module tb_axi_mm_chk_sequencer;

  localparam int TMO_W = 16;
  localparam int ST_IDLE = 0, ST_BLANK = 2, ST_LAUNCH = 3, ST_WAIT = 4, ST_GAP = 5;

  logic             rdclk = 1'b0;
  logic             rst_n, start, stop, chkr_fifo_full;
  logic [7:0]       cfg_num_iter, cfg_burst_len, cfg_gap;
  logic [TMO_W-1:0] cfg_timeout;
  logic [1:0]       patchkr_out;
  logic             patchkr_en, patgen_start, busy, done, pass, timeout_err;
  logic [7:0]       patgen_cnt, iter_cnt, pass_cnt, fail_cnt;
  logic [2:0]       state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int done_pulses = 0;
  int en_pulses = 0;
  int g_gap = 0;

  axi_mm_chk_sequencer #(.BLANK_CYC(6), .TMO_W(TMO_W)) dut (
    .rdclk(rdclk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_num_iter(cfg_num_iter), .cfg_burst_len(cfg_burst_len),
    .cfg_gap(cfg_gap), .cfg_timeout(cfg_timeout),
    .chkr_fifo_full(chkr_fifo_full), .patchkr_out(patchkr_out),
    .patchkr_en(patchkr_en), .patgen_start(patgen_start),
    .patgen_cnt(patgen_cnt), .busy(busy), .done(done), .pass(pass),
    .timeout_err(timeout_err), .iter_cnt(iter_cnt), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 rdclk = ~rdclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pulse monitors
  always @(negedge rdclk) begin
    if (done)       done_pulses++;
    if (patchkr_en) en_pulses++;
  end

  // driver tasks
  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives start for cycle 0 and returns in cycle 1.
  task automatic start_run(input logic [7:0] n, input logic [7:0] bl,
                           input logic [7:0] g, input logic [15:0] tmo,
                           input bit with_stop);
    cfg_num_iter  = n;
    cfg_burst_len = bl;
    cfg_gap       = g;
    cfg_timeout   = tmo;
    g_gap         = int'(g);
    start         = 1'b1;
    stop          = with_stop;
    tick();
    start         = 1'b0;
    stop          = 1'b0;
  endtask

  task automatic wait_launch(input int limit);
    int k = 0;
    while (!patgen_start && k < limit) begin
      tick();
      k++;
    end
    chk("launch seen", 32'(patgen_start), 1);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done && k < limit) begin
      tick();
      k++;
    end
    chk("done seen", 32'(done), 1);
  endtask

  // One iteration: launch L, verdict v driven at t = L+3, optional stop at
  // L+1. Returns at t+2+G (next ARM cycle, or FIN cycle when last).
  task automatic iterate(input logic [1:0] v, input bit do_stop, input bit last);
    wait_launch(60);
    tick();
    if (do_stop) stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("in wait", 32'(state_dbg), ST_WAIT);
    patchkr_out = v;
    tick();
    patchkr_out = 2'b00;
    chk("gap entry", 32'(state_dbg), ST_GAP);
    repeat (g_gap) tick();
    chk("no early arm", 32'(patchkr_en), 0);
    tick();
    if (last) chk("done pulse", 32'(done), 1);
    else      chk("next arm", 32'(patchkr_en), 1);
  endtask

  initial begin
    int base;
    int n;
    int seen;
    int notbusy;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; chkr_fifo_full = 1'b0;
    patchkr_out = 2'b00; cfg_num_iter = 8'd0; cfg_burst_len = 8'd0;
    cfg_gap = 8'd0; cfg_timeout = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst state", 32'(state_dbg), ST_IDLE);
    chk("rst ctrl", 32'({patchkr_en, patgen_start, busy, done, pass, timeout_err}), 0);
    chk("rst counters", 32'({patgen_cnt, iter_cnt, pass_cnt, fail_cnt}), 0);

    // single pass: launch at cycle 8, verdict 11 at 28, done at 30
    base = done_pulses;
    start_run(8'd1, 8'd16, 8'd0, 16'd1000, 1'b0);
    chk("t1 busy c1", 32'(busy), 1);
    chk("t1 arm c1", 32'(patchkr_en), 1);
    chk("t1 patgen_cnt", 32'(patgen_cnt), 16);
    repeat (6) tick();
    chk("t1 blank c7", 32'({state_dbg, patgen_start}), (ST_BLANK << 1));
    tick();
    chk("t1 launch c8", 32'(patgen_start), 1);
    repeat (20) tick();
    chk("t1 wait c28", 32'(state_dbg), ST_WAIT);
    patchkr_out = 2'b11;
    tick();
    patchkr_out = 2'b00;
    chk("t1 pass_cnt c29", 32'(pass_cnt), 1);
    tick();
    chk("t1 done c30", 32'({done, pass, busy}), 3'b111);
    tick();
    chk("t1 idle c31", 32'({done, busy}), 0);
    chk("t1 counters", 32'({iter_cnt, pass_cnt, fail_cnt}), {8'd1, 8'd1, 8'd0});
    chk("t1 pass held", 32'(pass), 1);
    chk("t1 one done", done_pulses - base, 1);

    // mixed verdicts, gap 5; a start pulse mid-run must be ignored
    base = en_pulses;
    start_run(8'd4, 8'd8, 8'd5, 16'd1000, 1'b0);
    iterate(2'b11, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    iterate(2'b10, 1'b0, 1'b0);
    iterate(2'b11, 1'b0, 1'b0);
    iterate(2'b11, 1'b0, 1'b1);
    chk("t2 pass at done", 32'(pass), 0);
    tick();
    chk("t2 busy low", 32'(busy), 0);
    chk("t2 counters", 32'({iter_cnt, pass_cnt, fail_cnt}), {8'd4, 8'd3, 8'd1});
    chk("t2 arm pulses", en_pulses - base, 4);

    // timeout T=50, gap 2: WAIT entry L+1, GAP at L+52, done at L+55
    start_run(8'd1, 8'd8, 8'd2, 16'd50, 1'b0);
    wait_launch(60);
    tick();
    repeat (50) tick();
    chk("t3 still wait", 32'({state_dbg, timeout_err}), (ST_WAIT << 1));
    tick();
    chk("t3 gap on timeout", 32'({state_dbg, timeout_err}), (ST_GAP << 1) | 1);
    chk("t3 fail_cnt", 32'(fail_cnt), 1);
    repeat (3) tick();
    chk("t3 done", 32'({done, pass}), 2'b10);
    tick();
    chk("t3 busy low", 32'(busy), 0);

    // continuous mode, stop in WAIT of iteration 3
    start_run(8'd0, 8'd8, 8'd1, 16'd1000, 1'b0);
    iterate(2'b11, 1'b0, 1'b0);
    iterate(2'b11, 1'b0, 1'b0);
    iterate(2'b11, 1'b1, 1'b1);
    tick();
    chk("t4 end", 32'({busy, pass, iter_cnt, pass_cnt}), {1'b0, 1'b1, 8'd3, 8'd3});

    // backpressure: full high through cycle 37, low from 38, stale 11 on
    // the verdict input while stalled; launch pulse lands at cycle 39
    chkr_fifo_full = 1'b1;
    patchkr_out    = 2'b11;
    start_run(8'd1, 8'd8, 8'd0, 16'd1000, 1'b0);
    seen = 0;
    notbusy = 0;
    for (int c = 2; c <= 38; c++) begin
      tick();
      if (patgen_start) seen++;
      if (!busy) notbusy++;
    end
    chkr_fifo_full = 1'b0;
    chk("t5 no launch while full", seen, 0);
    chk("t5 busy held", notbusy, 0);
    chk("t5 stalled c38", 32'({state_dbg, pass_cnt}), {3'(ST_LAUNCH), 8'd0});
    tick();
    patchkr_out = 2'b00;
    chk("t5 launch c39", 32'(patgen_start), 1);
    tick();
    patchkr_out = 2'b10;
    tick();
    patchkr_out = 2'b00;
    tick();
    chk("t5 done c42", 32'({done, pass, pass_cnt, fail_cnt}), {2'b10, 8'd0, 8'd1});
    tick();

    // reset mid-WAIT of iteration 2
    start_run(8'd3, 8'd8, 8'd0, 16'd1000, 1'b0);
    iterate(2'b11, 1'b0, 1'b0);
    wait_launch(60);
    tick();
    tick();
    chk("t6 in wait", 32'({state_dbg, iter_cnt}), {3'(ST_WAIT), 8'd1});
    base = done_pulses;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6 idle", 32'(state_dbg), ST_IDLE);
    chk("t6 ctrl zero", 32'({patchkr_en, patgen_start, busy, done, pass, timeout_err}), 0);
    chk("t6 counters zero", 32'({patgen_cnt, iter_cnt, pass_cnt, fail_cnt}), 0);
    repeat (4) tick();
    chk("t6 no done", done_pulses - base, 0);

    // stale 11 held through ARM/BLANK/LAUNCH, then 10 in WAIT
    patchkr_out = 2'b11;
    start_run(8'd1, 8'd8, 8'd0, 16'd1000, 1'b0);
    wait_launch(60);
    patchkr_out = 2'b00;
    chk("t7 stale ignored", 32'(pass_cnt), 0);
    tick();
    patchkr_out = 2'b10;
    tick();
    patchkr_out = 2'b00;
    chk("t7 wait sample", 32'({pass_cnt, fail_cnt}), {8'd0, 8'd1});
    tick();
    chk("t7 done", 32'({done, pass}), 2'b10);
    tick();

    // start and stop together: exactly one iteration of three
    start_run(8'd3, 8'd8, 8'd0, 16'd1000, 1'b1);
    iterate(2'b11, 1'b0, 1'b1);
    tick();
    chk("t8 one iter", 32'({busy, pass, iter_cnt}), {1'b0, 1'b1, 8'd1});

    // saturation and wrap: 260 timed-out iterations (T=1), continuous
    start_run(8'd0, 8'd4, 8'd0, 16'd1, 1'b0);
    n = patchkr_en ? 1 : 0;
    seen = 0;
    while (n < 260 && seen < 6000) begin
      tick();
      seen++;
      if (patchkr_en) n++;
    end
    chk("t9 arm count", n, 260);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(100);
    tick();
    chk("t9 fail sat", 32'(fail_cnt), 255);
    chk("t9 iter wrap", 32'({iter_cnt, pass_cnt}), {8'd4, 8'd0});
    chk("t9 flags", 32'({busy, pass, timeout_err}), 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
